div_seq: RTL and testbench

//  Sequential unsigned restoring divider; arithmetic inverse of the multiplier
//  in the same datapath. Divides a 2*SZ-bit dividend (e.g. a product) by an
//  SZ-bit divisor, one quotient bit per clock, giving SZ-bit quotient and

---
 rtl/mult_div_pkg.sv | 14 +
 rtl/div_step.sv | 28 ++
 rtl/div_seq.sv | 100 ++++++++++
 tb/tb_div_seq.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// Shared types and width helpers for the multiply/divide datapath.
package mult_div_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;

   // Counter width able to hold 0..sz inclusive.
   function automatic int cnt_w(input int sz);
      return $clog2(sz + 1);
   endfunction

   localparam int SZ_DEF = 32;
   localparam int CNT_W  = cnt_w(SZ_DEF);

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract.
module div_step #(
   parameter int SZ = 32
) (
   input  logic [SZ:0]   r,
   input  logic          q_msb,
   input  logic [SZ-1:0] b,
   output logic [SZ:0]   r_next,
   output logic          qbit
);

   logic [SZ:0] t;
   logic        ge;

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      t      = {r[SZ-1:0], q_msb};
      // A set r[SZ] means the shifted value already exceeds any SZ-bit divisor.
      ge     = r[SZ] | (t >= {1'b0, b});
      r_next = t;
      qbit   = 1'b0;
      if (ge) begin
         r_next = t - {1'b0, b};
         qbit   = 1'b1;
      end
   end

endmodule

// File: rtl/div_seq.sv
// Sequential unsigned restoring divider: 2*SZ-bit dividend / SZ-bit divisor,
// one quotient bit per clock, with divide-by-zero and overflow short cuts.
module div_seq
   import mult_div_pkg::*;
#(
   parameter int SZ = 32
) (
   input  logic            clk,
   input  logic            _rst,
   input  logic [2*SZ-1:0] a,
   input  logic [SZ-1:0]   b,
   input  logic            start,
   output logic [SZ-1:0]   quot,
   output logic [SZ-1:0]   rem,
   output logic            dbz,
   output logic            ovf,
   output logic            ready
);

   localparam int CW = cnt_w(SZ);

   div_state_e      state, state_next;
   logic [CW-1:0]   cnt;
   logic [SZ-1:0]   b_r, q, q_next;
   logic [SZ:0]     r, r_next;
   logic            qbit, spec_dbz, spec_ovf;
   logic            accept, last_step, finish;

   assign ready     = (state != BUSY);
   assign accept    = start && ready;
   assign last_step = (cnt == CW'(SZ - 1));
   assign finish    = (state == BUSY) && (spec_dbz || spec_ovf || last_step);
   assign q_next    = {q[SZ-2:0], qbit};

   div_step #(.SZ(SZ)) u_step (
      .r      (r),
      .q_msb  (q[SZ-1]),
      .b      (b_r),
      .r_next (r_next),
      .qbit   (qbit)
   );

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge _rst) begin
      if (!_rst) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE, DONE: if (start)  state_next = BUSY;
         BUSY:       if (finish) state_next = DONE;
         default:                state_next = IDLE;
      endcase
   end

   // NOTE: operand and working registers are reset too, so an aborted run leaves no stale state.
   always_ff @(posedge clk or negedge _rst) begin
      if (!_rst) begin
         b_r      <= '0;
         r        <= '0;
         q        <= '0;
         cnt      <= '0;
         spec_dbz <= 1'b0;
         spec_ovf <= 1'b0;
         quot     <= '0;
         rem      <= '0;
         dbz      <= 1'b0;
         ovf      <= 1'b0;
      end else if (accept) begin
         b_r      <= b;
         r        <= {1'b0, a[2*SZ-1:SZ]};
         q        <= a[SZ-1:0];
         cnt      <= '0;
         spec_dbz <= (b == '0);
         spec_ovf <= (b != '0) && (a[2*SZ-1:SZ] >= b);
         dbz      <= 1'b0;
         ovf      <= 1'b0;
      end else if (state == BUSY) begin
         r <= r_next;
         q <= q_next;
         if (!last_step) cnt <= cnt + 1'b1;
         if (spec_dbz) begin
            // q still holds the low dividend half here.
            quot <= '1;
            rem  <= q;
            dbz  <= 1'b1;
         end else if (spec_ovf) begin
            quot <= '1;
            rem  <= '0;
            ovf  <= 1'b1;
         end else if (last_step) begin
            quot <= q_next;
            rem  <= r_next[SZ-1:0];
         end
      end
   end

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: directed corner cases plus randomized a = x*y+z.
module tb_div_seq;

   localparam int SZ = 32;

   logic          clk   = 1'b0;
   logic          _rst  = 1'b0;
   logic          start = 1'b0;
   logic [63:0]   a     = '0;
   logic [31:0]   b     = '0;
   logic [31:0]   quot, rem;
   logic          dbz, ovf, ready;

   div_seq #(.SZ(SZ)) dut (
      .clk   (clk),
      ._rst  (_rst),
      .a     (a),
      .b     (b),
      .start (start),
      .quot  (quot),
      .rem   (rem),
      .dbz   (dbz),
      .ovf   (ovf),
      .ready (ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] quot;
      logic [31:0] rem;
      logic        dbz;
      logic        ovf;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   int          checks   = 0;
   int          failures = 0;
   logic [31:0] last_quot = '0;
   logic [31:0] last_rem  = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain 64-bit integer division plus the two exceptional outcomes.
   function automatic exp_t model(input logic [63:0] av, input logic [31:0] bv);
      exp_t        e;
      logic [63:0] qq, rr;
      e.dbz = 1'b0;
      e.ovf = 1'b0;
      e.lat = SZ;
      if (bv == 32'd0) begin
         e.dbz  = 1'b1;
         e.quot = '1;
         e.rem  = av[31:0];
         e.lat  = 1;
      end else begin
         qq = av / {32'd0, bv};
         rr = av % {32'd0, bv};
         if (qq[63:32] != 32'd0) begin
            e.ovf  = 1'b1;
            e.quot = '1;
            e.rem  = '0;
            e.lat  = 1;
         end else begin
            e.quot = qq[31:0];
            e.rem  = rr[31:0];
         end
      end
      return e;
   endfunction

   // Monitor: pops on each rising ready, checks result and busy length,
   // and checks that outputs hold while busy or idle.
   initial begin
      logic prev_ready;
      int   busy_cnt;
      exp_t e;
      prev_ready = 1'b1;
      busy_cnt   = 0;
      forever begin
         @(negedge clk);
         if (!_rst) begin
            prev_ready = 1'b1;
            busy_cnt   = 0;
         end else begin
            if (!ready) begin
               busy_cnt++;
               check("busy_quot_hold", quot, last_quot);
               check("busy_rem_hold", rem, last_rem);
               check("busy_flags_clear", {dbz, ovf}, 2'b00);
            end else if (!prev_ready) begin
               if (sb.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_done: got completion expected none at %0t", $time);
               end else begin
                  e = sb.pop_front();
                  check("quot", quot, e.quot);
                  check("rem", rem, e.rem);
                  check("dbz", dbz, e.dbz);
                  check("ovf", ovf, e.ovf);
                  check("busy_cycles", busy_cnt, e.lat);
                  last_quot = e.quot;
                  last_rem  = e.rem;
               end
               busy_cnt = 0;
            end else begin
               check("idle_quot_hold", quot, last_quot);
               check("idle_rem_hold", rem, last_rem);
            end
            prev_ready = ready;
         end
      end
   end

   task automatic issue(input logic [63:0] av, input logic [31:0] bv);
      int n;
      n = 0;
      @(negedge clk);
      while (!ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!ready) begin
         checks++;
         failures++;
         $display("FAIL issue_timeout: got ready=0 expected ready=1 at %0t", $time);
      end
      a     = av;
      b     = bv;
      start = 1'b1;
      sb.push_back(model(av, bv));
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL wait_idle_timeout: got %0d pending expected 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      logic [31:0] x, y, z, bv, ahi;
      logic [63:0] av;
      int          kind;

      _rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ready", ready, 1'b1);
      check("reset_quot", quot, 32'd0);
      check("reset_rem", rem, 32'd0);
      check("reset_dbz", dbz, 1'b0);
      check("reset_ovf", ovf, 1'b0);
      @(negedge clk);
      _rst = 1'b1;

      issue(64'd100, 32'd7);                          wait_idle();
      issue(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF);  wait_idle();
      issue(64'd55, 32'd0);                           wait_idle();
      issue(64'h0000_0005_0000_0000, 32'd5);          wait_idle();

      // A start pulse during BUSY must be ignored entirely.
      issue(64'd1000, 32'd3);
      repeat (3) @(negedge clk);
      a     = 64'd9;
      b     = 32'd9;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check("ignored_start_ready", ready, 1'b0);
      wait_idle();

      // Asynchronous reset mid-operation clears everything immediately.
      issue(64'd123456789, 32'd77);
      repeat (5) @(posedge clk);
      #2 _rst = 1'b0;
      #1;
      sb.delete();
      last_quot = '0;
      last_rem  = '0;
      check("abort_ready", ready, 1'b1);
      check("abort_quot", quot, 32'd0);
      check("abort_rem", rem, 32'd0);
      check("abort_flags", {dbz, ovf}, 2'b00);
      @(negedge clk);
      #1 _rst = 1'b1;

      // Randomized, back-to-back issues.
      for (int i = 0; i < 1000; i++) begin
         kind = $urandom_range(0, 19);
         if (kind == 0) begin
            av = {$urandom, $urandom};
            bv = 32'd0;
         end else if (kind == 1) begin
            ahi = $urandom;
            if (ahi == 32'd0) ahi = 32'd1;
            bv = ($urandom % ahi) + 32'd1;
            av = {ahi, $urandom};
         end else begin
            y = (kind < 6) ? $urandom_range(1, 255) : $urandom;
            if (y == 32'd0) y = 32'd1;
            x = $urandom;
            z = $urandom % y;
            av = {32'd0, x} * {32'd0, y} + {32'd0, z};
            bv = y;
         end
         issue(av, bv);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      wait_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
